// File: rtl/j17_display_pkg.sv
// Shared constants for the J17 hex display: glyph table, blank pattern and digit index type.
// Glyphs are active-low with bit order g..a, so bit 0 drives segment a.
package j17_display_pkg;

  localparam int NUM_DIGITS_C = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational nibble-to-glyph decoder for one 7-segment digit (active-low segments).
module hex_to_seg7
  import j17_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = GLYPH[nibble];
  end

endmodule

// File: rtl/seg_scan_display.sv
// Shadow-latched 32-bit hex display scanned across 8 multiplexed 7-segment digits.
// Optional macro SEG_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module seg_scan_display
  import j17_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int NUM_DIGITS  = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] value,
  input  logic        load,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic [7:0]  an,
  output logic        dp
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] TERM = CW'(REFRESH_DIV - 1);

  if (NUM_DIGITS != NUM_DIGITS_C || REFRESH_DIV < 2 || REFRESH_DIV > (1 << 20)) begin : g_bad_param
    $error("seg_scan_display: NUM_DIGITS must be 8 and REFRESH_DIV within 2..2^20");
  end

  logic [31:0]   shadow_q, shadow_d;
  logic [CW-1:0] cnt_q, cnt_d;
  digit_idx_t    idx_q, idx_d;
  logic [7:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick;

  logic [6:0] glyph [NUM_DIGITS_C];
  logic [7:0] upper_zero;

  for (genvar gi = 0; gi < NUM_DIGITS_C; gi++) begin : g_dec
    hex_to_seg7 u_dec (
      .nibble (shadow_q[gi*4 +: 4]),
      .seg_n  (glyph[gi])
    );
  end

`ifdef SEG_LEADING_ZERO_BLANK_EN
  // Digit k blanks when every nibble from k upward is zero; digit 0 never blanks.
  assign upper_zero[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS_C; gi++) begin : g_lz
    assign upper_zero[gi] = ~|(shadow_q >> (gi * 4));
  end
`else
  assign upper_zero = '0;
`endif

  assign tick = (cnt_q == TERM);

  always_comb begin
    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    shadow_d = (load && !hold) ? value : shadow_q;
    // Outputs follow the pre-edge idx/shadow, giving one register stage of latency.
    an_d     = ~(8'h01 << idx_q);
    seg_d    = upper_zero[idx_q] ? SEG_BLANK : glyph[idx_q];
    dp_d     = ~((idx_q == 3'd0) && (shadow_q != 32'h0));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shadow_q <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      an_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
      dp_q     <= 1'b1;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;
  assign dp  = dp_q;

endmodule
